alu_cmd_sequencer: RTL

Command front-end for the 8-bit ALU: accepts operand/opcode commands over a valid/ready handshake, buffers them in a small FIFO, and drives registered `opA`/`opB`/`opS` into the combinational ALU `top`. It captures `Result` into an output register carrying a sequence tag and an error flag. It sits directly upstream of the ALU and owns both its operand inputs and its result output.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 72 +++++++
 rtl/alu_cmd_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcode map, data widths
// and the command record carried through the FIFO and issue stage.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OPS_W  = 4;

  localparam logic [OPS_W-1:0] OP_NOP    = 4'd0;
  localparam logic [OPS_W-1:0] OP_ADD    = 4'd1;
  localparam logic [OPS_W-1:0] OP_SUB    = 4'd2;
  localparam logic [OPS_W-1:0] OP_AND    = 4'd3;
  localparam logic [OPS_W-1:0] OP_OR     = 4'd4;
  localparam logic [OPS_W-1:0] OP_XOR    = 4'd5;
  localparam logic [OPS_W-1:0] OP_INVERT = 4'd6;
  localparam logic [OPS_W-1:0] OP_SHL    = 4'd7;
  localparam logic [OPS_W-1:0] OP_SHR    = 4'd8;
  localparam logic [OPS_W-1:0] OP_LAST   = OP_SHR;

  typedef struct packed {
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [OPS_W-1:0]  opS;
  } aluCmd_t;

  localparam int CMD_W = $bits(aluCmd_t);

  // Opcodes above OP_LAST are never forwarded to the ALU.
  function automatic logic isLegalOp(input logic [OPS_W-1:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count, full and empty.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module alu_cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] countNext;
  logic             doPush;
  logic             doPop;

  // Full/empty come straight from the registered count, so a pop at full
  // cannot open a slot for a push in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    countNext = count;
    if (doPush && !doPop) begin
      countNext = count + CNT_W'(1);
    end else if (!doPush && doPop) begin
      countNext = count - CNT_W'(1);
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; an entry is only read after it has been written, and leaving it unreset keeps it in plain RAM cells.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register sees the pre-edge values of the others.
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= countNext;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit ALU: FIFO -> issue register (opA/opB/opS)
// -> external combinational ALU -> tagged output register.
// Optional result flags (out_zero/out_parity) are built only when the macro
// ALU_SEQ_FLAGS_EN is defined; otherwise both are tied low.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_opA,
  input  logic [DATA_W-1:0] in_opB,
  input  logic [OPS_W-1:0]  in_opS,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic [OPS_W-1:0]  opS,
  input  logic [DATA_W-1:0] Result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              out_zero,
  output logic              out_parity
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  aluCmd_t           inCmd;
  aluCmd_t           headCmd;
  logic [CNT_W-1:0]  fifoCount;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              popEn;
  logic              outAdvance;
  logic              issueAdvance;
  logic              issueValid;
  logic              issueErr;
  logic              issueBeat;
  logic [DATA_W-1:0] beatResult;
  logic [TAG_W-1:0]  tagCnt;

  assign inCmd    = '{opA: in_opA, opB: in_opB, opS: in_opS};
  assign in_ready = ~fifoFull;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid),
    .pushData (inCmd),
    .pop      (popEn),
    .popData  (headCmd),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Output stage moves when empty or drained; issue stage moves with it or
  // whenever it holds nothing. The FIFO pops exactly when issue loads.
  assign outAdvance   = ~out_valid | out_ready;
  assign issueAdvance = outAdvance | ~issueValid;
  assign popEn        = issueAdvance & ~fifoEmpty;

  // NOPs flow through issue but never become a beat; illegal ops always do.
  assign issueBeat = issueValid & (issueErr | (opS != OP_NOP));

  // Beat payload: illegal opcodes report zero instead of the ALU output.
  always_comb begin
    beatResult = Result;
    if (issueErr) begin
      beatResult = '0;
    end
  end

  // Issue register: drives the ALU operands, illegal opcodes replaced by NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issueValid <= 1'b0;
      issueErr   <= 1'b0;
      opA        <= '0;
      opB        <= '0;
      opS        <= OP_NOP;
    end else if (issueAdvance) begin
      issueValid <= ~fifoEmpty;
      if (!fifoEmpty) begin
        opA <= headCmd.opA;
        opB <= headCmd.opB;
        if (isLegalOp(headCmd.opS)) begin
          opS      <= headCmd.opS;
          issueErr <= 1'b0;
        end else begin
          opS      <= OP_NOP;
          issueErr <= 1'b1;
        end
      end
    end
  end

  // Output register and sequence tag; contents hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
      out_tag    <= '0;
      tagCnt     <= '0;
    end else if (outAdvance) begin
      out_valid <= issueBeat;
      if (issueBeat) begin
        out_result <= beatResult;
        out_err    <= issueErr;
        out_tag    <= tagCnt;
        tagCnt     <= tagCnt + TAG_W'(1);
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Result flags registered alongside the beat they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
    end else if (outAdvance && issueBeat) begin
      out_zero   <= (beatResult == '0);
      out_parity <= ^beatResult;
    end
  end
`else
  assign out_zero   = 1'b0;
  assign out_parity = 1'b0;
`endif

  // Occupancy must never exceed the FIFO depth.
  always_comb begin
    assert (fifoCount <= CNT_W'(DEPTH));
  end

endmodule
